ro_pair_counter: RTL and testbench
==================================

# ro_pair_counter

Measurement stage directly downstream of a pair of ring oscillators in the delay-based PUF. On request it enables both oscillators, synchronises their outputs into the system clock domain, and counts rising edges of each over a fixed window of system clocks. It then compares the two counts and produces one PUF response bit. Higher-level response assembly uses this block as its per-bit primitive.

## Interface
- `WINDOW_CYCLES`, 4096: length of the counting window in `clk` cycles; must be ≥ 1.
- `CNT_W`, 16: width of each edge counter in bits.
- `SETTLE_CYCLES`, 64: oscillator warm-up cycles after enable. Used only when `PUF_SETTLE_EN` is defined; must be ≥ 1.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request to begin a measurement.
- `ro_a` input 1: raw output of oscillator A. Asynchronous to `clk`.
- `ro_b` input 1: raw output of oscillator B. Asynchronous to `clk`.
- `ro_en` output 1: enable to both oscillators; drives their NAND gate.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle pulse when the results are valid.
- `resp_bit` output 1: 1 when `count_a` > `count_b`, else 0.
- `tie` output 1: 1 when `count_a` == `count_b`.
- `overflow` output 1: 1 if either counter saturated during the window.
- `count_a` output CNT_W: final edge count for oscillator A.
- `count_b` output CNT_W: final edge count for oscillator B.

## Operation
- FSM states and transitions:
  - IDLE → SETTLE on `start`.
  - SETTLE → COUNT after `SETTLE_CYCLES` cycles.
  - COUNT → RESULT after `WINDOW_CYCLES` cycles.
  - RESULT → IDLE after one cycle.
- Without `PUF_SETTLE_EN`: IDLE → COUNT directly.
- `ro_en` is high in SETTLE and COUNT and low in IDLE and RESULT. The oscillators therefore run only while a measurement is in progress.
- `ro_a` and `ro_b` each pass through a 2-flop synchroniser, then a registered rising-edge detector (current synchronised value high, previous value low).
- A detected edge increments its counter only while in COUNT. Edges still in the synchroniser pipeline when COUNT ends are discarded.
- Both counters clear to 0 on the IDLE→SETTLE/COUNT transition.
- Counters saturate at 2^CNT_W−1 and never wrap. Saturation sets a sticky overflow flag for the current measurement.
- Comparison in RESULT is an unsigned CNT_W-bit compare. On a tie, `resp_bit`=0 and `tie`=1.
- `count_a`, `count_b`, `resp_bit`, `tie` and `overflow` are registered in RESULT and held until the next accepted `start`.
- `start` while `busy` is ignored: no restart, no queueing.
- `start` coinciding with the RESULT cycle is also ignored. The next `start` is accepted from IDLE only.
- Operating constraint: oscillator frequency must be < f_clk/2. Higher rates alias, and this block does not detect it.

## Timing
- Reset values: state IDLE; `ro_en`, `busy`, `done`, `resp_bit`, `tie`, `overflow` all 0; `count_a`, `count_b` both 0; synchroniser and edge-detect flops 0.
- `start` sampled high at edge N (in IDLE):
  - `ro_en` and `busy` are high after edge N.
  - COUNT occupies exactly `WINDOW_CYCLES` cycles.
  - `done` is high for the single cycle after edge N + S + WINDOW_CYCLES + 1, where S = `SETTLE_CYCLES`, or 0 when the macro is absent.
- `busy` falls in the same cycle that `done` rises.
- `ro_en` falls at entry to RESULT, one cycle before `done`.
- Reset asserted mid-operation: all outputs and the FSM return to reset values immediately (asynchronously), and `ro_en` drops at once. Previous results are lost.

## Configuration
- `PUF_SETTLE_EN` defined: the SETTLE state exists and oscillators run `SETTLE_CYCLES` before counting, so start-up transients are excluded.
- `PUF_SETTLE_EN` undefined: there is no SETTLE state, the `SETTLE_CYCLES` parameter is unused, and latency is reduced by `SETTLE_CYCLES`.

## Structure
- Shared package `puf_pkg`:
  - FSM state enum (IDLE, SETTLE, COUNT, RESULT).
  - Constant `PUF_SYNC_STAGES` = 2.
- Sub-module `ro_edge_counter`: synchroniser, edge detect, and saturating counter with `count_en`/`clear` inputs and a sticky `sat` output. It is instantiated once per oscillator.

## Test plan
- clk 10 ns, `ro_a` 40 ns, `ro_b` 50 ns, WINDOW=1000 → `count_a`=250±1, `count_b`=200±1, `resp_bit`=1, `tie`=0, `overflow`=0, `done` exactly one cycle.
- Swap the periods → `resp_bit`=0 and the counts swap.
- Both inputs 40 ns, phase-aligned → `tie`=1, `resp_bit`=0.
- CNT_W=8, WINDOW=2000, `ro_a` 40 ns → `count_a`=255, `overflow`=1, no wrap.
- `start` pulsed again mid-COUNT → ignored; `done` occurs at the original scheduled cycle.
- `rst_n` low mid-COUNT → `ro_en`=0, `busy`=0, all counts 0 immediately; a later `start` gives a correct full measurement.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared definitions for the ring-oscillator PUF measurement blocks.
//   puf_state_e      : measurement FSM states (IDLE, SETTLE, COUNT, RESULT)
//   PUF_SYNC_STAGES  : depth of the oscillator-to-clk synchroniser
//   max_u            : helper returning the larger of two unsigned values
package puf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COUNT,
    RESULT
  } puf_state_e;

  localparam int unsigned PUF_SYNC_STAGES = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Per-oscillator front end: 2-flop synchroniser, registered rising-edge
// detector and a saturating edge counter.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   ro         : raw oscillator output (asynchronous to clk)
//   count_en   : count detected edges while high
//   clear      : zero the counter and the sticky saturation flag
//   count      : current edge count (CNT_W bits, saturating)
//   sat        : sticky; set when an edge arrives while count is at its ceiling
module ro_edge_counter
  import puf_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro,
  input  logic             count_en,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [PUF_SYNC_STAGES-1:0] sync;
  logic                       sync_prev;
  logic                       edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= '0;
      sync_prev <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      sync      <= {sync[PUF_SYNC_STAGES-2:0], ro};
      sync_prev <= sync[PUF_SYNC_STAGES-1];
      edge_q    <= sync[PUF_SYNC_STAGES-1] & ~sync_prev;
    end
  end

  // Edges are only counted while count_en is high; anything still in the
  // synchroniser when counting stops is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (count_en && edge_q) begin
      if (count == '1) begin
        sat <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ro_pair_counter.sv
// Ring-oscillator pair measurement: enables both oscillators on request,
// counts synchronised rising edges of each over WINDOW_CYCLES clk cycles and
// produces one PUF response bit from the comparison.
// Optional feature macro: PUF_SETTLE_EN adds a SETTLE_CYCLES warm-up phase
// (oscillators enabled, edges not counted) before the counting window.
// Ports:
//   clk, rst_n       : system clock, asynchronous active-low reset
//   start            : single-cycle request, accepted only in IDLE
//   ro_a, ro_b       : raw oscillator outputs (asynchronous)
//   ro_en            : oscillator enable, high in SETTLE and COUNT
//   busy             : measurement in progress
//   done             : one-cycle pulse, results valid
//   resp_bit         : count_a > count_b
//   tie              : count_a == count_b
//   overflow         : either counter saturated in the window
//   count_a, count_b : final edge counts, held until the next result
module ro_pair_counter
  import puf_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 4096,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SETTLE_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic             resp_bit,
  output logic             tie,
  output logic             overflow,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  // One phase timer is shared by SETTLE and COUNT, sized for the longer one.
  localparam int unsigned TMR_MAX = max_u(WINDOW_CYCLES, SETTLE_CYCLES);
  localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WINDOW_CYCLES - 1);
`ifdef PUF_SETTLE_EN
  localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYCLES - 1);
`endif

  puf_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             clear;
  logic             count_en;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic             sat_a, sat_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          timer_d = '0;
`ifdef PUF_SETTLE_EN
          state_d = SETTLE;
`else
          state_d = COUNT;
`endif
        end
      end
`ifdef PUF_SETTLE_EN
      SETTLE: begin
        if (timer_q == SET_LAST) begin
          timer_d = '0;
          state_d = COUNT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      COUNT: begin
        if (timer_q == WIN_LAST) begin
          timer_d = '0;
          state_d = RESULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decoded straight from the state register so reset removes them at once.
  assign count_en = (state_q == COUNT);
  assign ro_en    = (state_q == SETTLE) || (state_q == COUNT);
  assign busy     = (state_q != IDLE);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .ro       (ro_a),
    .count_en (count_en),
    .clear    (clear),
    .count    (cnt_a),
    .sat      (sat_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .ro       (ro_b),
    .count_en (count_en),
    .clear    (clear),
    .count    (cnt_b),
    .sat      (sat_b)
  );

  // Results are captured at the end of RESULT, so done and the new values
  // appear together in the first IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      resp_bit <= 1'b0;
      tie      <= 1'b0;
      overflow <= 1'b0;
      count_a  <= '0;
      count_b  <= '0;
    end else begin
      done <= (state_q == RESULT);
      if (state_q == RESULT) begin
        resp_bit <= (cnt_a > cnt_b);
        tie      <= (cnt_a == cnt_b);
        overflow <= sat_a | sat_b;
        count_a  <= cnt_a;
        count_b  <= cnt_b;
      end
    end
  end

endmodule

// File: tb/tb_ro_pair_counter.sv
`timescale 1ns/100ps
module tb_ro_pair_counter;

  localparam int unsigned W   = 1000;
  localparam int unsigned W8  = 2000;
  localparam int unsigned SET = 8;
`ifdef PUF_SETTLE_EN
  localparam int S = SET;
`else
  localparam int S = 0;
`endif
  localparam int T_WIN  = W * 10;
  localparam int T_WIN8 = W8 * 10;

  logic        clk, rst_n, start, start8;
  logic        ro_a_gen, ro_b_gen, tie_mode;
  logic        ro_a, ro_b;
  logic        ro_en, busy, done, resp_bit, tie, overflow;
  logic [15:0] count_a, count_b;
  logic        ro_en8, busy8, done8, resp_bit8, tie8, overflow8;
  logic [7:0]  count_a8, count_b8;

  int half_a = 20;
  int half_b = 25;
  int checks = 0;
  int fails  = 0;

  assign ro_a = ro_a_gen;
  assign ro_b = tie_mode ? ro_a_gen : ro_b_gen;

  ro_pair_counter #(.WINDOW_CYCLES(W), .CNT_W(16), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en), .busy(busy), .done(done), .resp_bit(resp_bit), .tie(tie),
    .overflow(overflow), .count_a(count_a), .count_b(count_b)
  );

  ro_pair_counter #(.WINDOW_CYCLES(W8), .CNT_W(8), .SETTLE_CYCLES(SET)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en8), .busy(busy8), .done(done8), .resp_bit(resp_bit8), .tie(tie8),
    .overflow(overflow8), .count_a(count_a8), .count_b(count_b8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running oscillators; fractional start offsets keep their edges off
  // the clock edges.
  initial begin
    ro_a_gen = 1'b0;
    #0.3;
    forever #(half_a) ro_a_gen = ~ro_a_gen;
  end

  initial begin
    ro_b_gen = 1'b0;
    #0.7;
    forever #(half_b) ro_b_gen = ~ro_b_gen;
  end

  // Drives one measurement on the main instance and checks the per-cycle
  // handshake against the latency rules. Cycle c is the cycle after edge N+c-1.
  task automatic measure(input string tag, input bit restart_mid, input bit start_in_result);
    int busy_err, roen_err, done_err, bad_c;
    busy_err = 0; roen_err = 0; done_err = 0; bad_c = -1;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= S + int'(W) + 3; c++) begin
      if (busy !== (c <= S + int'(W) + 1)) begin busy_err++; if (bad_c < 0) bad_c = c; end
      if (ro_en !== (c <= S + int'(W))) begin roen_err++; if (bad_c < 0) bad_c = c; end
      if (done !== (c == S + int'(W) + 2)) begin done_err++; if (bad_c < 0) bad_c = c; end
      start = (restart_mid && c == S + int'(W) / 2) ||
              (start_in_result && c == S + int'(W) + 1);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (busy_err !== 0) begin
      fails++;
      $display("FAIL %s busy_timing: %0d wrong cycles (first cycle %0d), required 0", tag, busy_err, bad_c);
    end
    checks++;
    if (roen_err !== 0) begin
      fails++;
      $display("FAIL %s ro_en_timing: %0d wrong cycles (first cycle %0d), required 0", tag, roen_err, bad_c);
    end
    checks++;
    if (done_err !== 0) begin
      fails++;
      $display("FAIL %s done_pulse: %0d wrong cycles (first cycle %0d), required 0", tag, done_err, bad_c);
    end
  endtask

  // Expected edge count over a window of t ns for period p ns is t/p, give
  // or take one edge from where the window falls relative to the waveform.
  task automatic check_count(input string tag, input int got, input int p, input int t);
    int err;
    err = got * p - t;
    checks++;
    if (err < -p || err > p) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d +/- 1", tag, got, t / p);
    end
  endtask

  task automatic check_pair(input string tag, input int pa, input int pb);
    half_a = pa / 2;
    half_b = pb / 2;
    measure(tag, 1'b0, 1'b0);
    check_count({tag, " count_a"}, int'(count_a), pa, T_WIN);
    check_count({tag, " count_b"}, int'(count_b), pb, T_WIN);
    checks++;
    if (resp_bit !== (pa < pb)) begin
      fails++;
      $display("FAIL %s resp_bit: got %0b, required %0b", tag, resp_bit, pa < pb);
    end
    checks++;
    if (tie !== 1'b0) begin
      fails++;
      $display("FAIL %s tie: got %0b, required 0", tag, tie);
    end
    checks++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL %s overflow: got %0b, required 0", tag, overflow);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ro_en, busy, done, resp_bit, tie, overflow} !== 6'b0 || count_a !== 16'd0 || count_b !== 16'd0) begin
      fails++;
      $display("FAIL reset_outputs: got en=%0b busy=%0b done=%0b resp=%0b tie=%0b ovf=%0b a=%0d b=%0d, required all 0",
               ro_en, busy, done, resp_bit, tie, overflow, count_a, count_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ro_en !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got busy=%0b done=%0b ro_en=%0b, required 0 0 0", busy, done, ro_en);
    end
  endtask

  task automatic test_basic();
    check_pair("basic_40_50", 40, 50);
  endtask

  task automatic test_swap();
    check_pair("swap_50_40", 50, 40);
  endtask

  task automatic test_tie();
    half_a = 20;
    tie_mode = 1'b1;
    measure("tie", 1'b0, 1'b0);
    tie_mode = 1'b0;
    check_count("tie count_a", int'(count_a), 40, T_WIN);
    checks++;
    if (tie !== 1'b1 || resp_bit !== 1'b0) begin
      fails++;
      $display("FAIL tie_flags: got tie=%0b resp=%0b (a=%0d b=%0d), required tie=1 resp=0",
               tie, resp_bit, count_a, count_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      int pa, pb;
      do begin
        pa = 2 * int'($urandom_range(12, 60));
        pb = 2 * int'($urandom_range(12, 60));
      end while ((T_WIN / pa - T_WIN / pb) < 4 && (T_WIN / pb - T_WIN / pa) < 4);
      check_pair($sformatf("random%0d_%0d_%0d", i, pa, pb), pa, pb);
    end
  endtask

  task automatic test_restart_mid();
    half_a = 20;
    half_b = 25;
    measure("restart_mid", 1'b1, 1'b0);
    check_count("restart_mid count_a", int'(count_a), 40, T_WIN);
    check_count("restart_mid count_b", int'(count_b), 50, T_WIN);
  endtask

  task automatic test_start_in_result();
    half_a = 25;
    half_b = 20;
    measure("start_in_result", 1'b0, 1'b1);
    checks++;
    if (resp_bit !== 1'b0) begin
      fails++;
      $display("FAIL start_in_result resp_bit: got %0b, required 0", resp_bit);
    end
  endtask

  task automatic test_overflow();
    int done_c, pulses;
    done_c = -1; pulses = 0;
    half_a = 20;
    half_b = 100;
    repeat (20) @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int c = 1; c <= S + int'(W8) + 6; c++) begin
      if (done8 === 1'b1) begin
        pulses++;
        if (done_c < 0) done_c = c;
      end
      @(negedge clk);
    end
    checks++;
    if (done_c !== S + int'(W8) + 2 || pulses !== 1) begin
      fails++;
      $display("FAIL ovf done8: got cycle %0d pulses %0d, required cycle %0d pulses 1", done_c, pulses, S + int'(W8) + 2);
    end
    checks++;
    if (count_a8 !== 8'd255) begin
      fails++;
      $display("FAIL ovf count_a8: got %0d, required 255", count_a8);
    end
    checks++;
    if (overflow8 !== 1'b1) begin
      fails++;
      $display("FAIL ovf overflow8: got %0b, required 1", overflow8);
    end
    check_count("ovf count_b8", int'(count_b8), 200, T_WIN8);
    checks++;
    if (resp_bit8 !== 1'b1) begin
      fails++;
      $display("FAIL ovf resp_bit8: got %0b, required 1", resp_bit8);
    end
  endtask

  task automatic test_reset_mid();
    half_a = 20;
    half_b = 25;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (S + int'(W) / 2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ro_en !== 1'b0 || busy !== 1'b0 || count_a !== 16'd0 || count_b !== 16'd0 || resp_bit !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got en=%0b busy=%0b a=%0d b=%0d resp=%0b done=%0b, required all 0",
               ro_en, busy, count_a, count_b, resp_bit, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_pair("after_reset_mid", 40, 50);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start8 = 1'b0;
    tie_mode = 1'b0;
    #22;
    test_reset();
    test_basic();
    test_swap();
    test_tie();
    test_random();
    test_restart_mid();
    test_start_in_result();
    test_overflow();
    test_basic();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
